cc_ben_unit: RTL and testbench
==============================

CC_BEN_UNIT -- requirements
Module: cc_ben_unit

Interface
REQ-001 Parameter WIDTH, default 16: width of the bus value that sets the condition codes.
REQ-002 Parameter SAVE_DEPTH, default 4: number of condition-code save slots for nested interrupt entry, allowed range 1..8.
REQ-003 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Bus  input  WIDTH  signed two's-complement value to be classified.
REQ-006 Load_CC  input  1  capture the NZP classification of Bus into CC.
REQ-007 IR_NZP  input  3  branch condition field from the instruction, bit order [2]=n, [1]=z, [0]=p.
REQ-008 Load_BEN  input  1  capture the branch-enable evaluation into BEN.
REQ-009 Save  input  1  push the current CC onto the save stack (interrupt entry).
REQ-010 Restore  input  1  pop the top of the save stack into CC (RTI).
REQ-011 CC  output  3  registered condition codes, one-hot n/z/p.
REQ-012 BEN  output  1  registered branch enable.
REQ-013 Depth  output  $clog2(SAVE_DEPTH+1)  number of occupied save slots.
REQ-014 Full / Empty  output  1 each  Depth==SAVE_DEPTH / Depth==0, combinational from Depth.
REQ-015 Err  output  1  sticky error flag.

Function
REQ-016 Classification: Bus[WIDTH-1]=1 -> CC=100; Bus==0 -> 010; otherwise 001. CC is always exactly one-hot.
REQ-017 Load_CC: CC updates on the edge after assertion, giving 1-cycle latency.
REQ-018 BEN evaluation: |(IR_NZP & CC), using the registered CC value present in that cycle, not a same-cycle Load_CC result.
REQ-019 Load_BEN: BEN updates with 1-cycle latency; BEN holds while Load_BEN=0. IR_NZP=000 yields BEN=0.
REQ-020 Save with not Full: the stack slot at index Depth receives the current CC, and Depth increments.
REQ-021 Restore with not Empty: CC takes the top slot, and Depth decrements.
REQ-022 Save with Load_CC in the same cycle: the old CC is pushed, and CC takes the new classification.
REQ-023 Restore with Load_CC in the same cycle: Restore wins and Load_CC is ignored.
REQ-024 Save with Restore in the same cycle: neither acts; Depth and CC are unchanged, and Err sets.
REQ-025 Save while Full (overflow): no push, Depth unchanged, CC still honours Load_CC, and Err sets.
REQ-026 Restore while Empty (underflow): CC is unchanged, Load_CC is still honoured, and Err sets.
REQ-027 Err clears only on reset.
REQ-028 Depth never wraps; it saturates at 0 and at SAVE_DEPTH.
REQ-029 Load_BEN is independent of Save and Restore; in a Restore cycle, BEN uses the pre-restore CC.

Reset
REQ-030 Reset_n low asynchronously forces CC=010, BEN=0, Depth=0 and Err=0.
REQ-031 Stack slot contents need not reset; they are unobservable while Depth=0.
REQ-032 Reset asserted mid-operation abandons all saved contexts; after release, the first Restore is an underflow.
REQ-033 Release is synchronised externally; the block requires no internal synchroniser.

Structure
REQ-034 A shared package cc_pkg holds: typedef cc_t (3-bit), constants CC_N=100, CC_Z=010, CC_P=001, CC_RESET=CC_Z, and a classify function parametrised by width.
REQ-035 One sub-module, cc_save_stack: a LIFO of cc_t entries, SAVE_DEPTH deep, with push/pop/full/empty/depth ports and no error logic.
REQ-036 Error detection, priority resolution and the CC/BEN registers reside in cc_ben_unit.

Verification
REQ-037 Bus=16'h8000 + Load_CC -> CC=100 next edge; Bus=0 -> 010; Bus=16'h0001 -> 001; WIDTH=8 with Bus=8'h80 -> 100.
REQ-038 CC=010, IR_NZP=010, Load_BEN -> BEN=1; IR_NZP=101 -> BEN=0; IR_NZP=000 -> BEN=0; same-cycle Load_CC to 001 with IR_NZP=001 -> BEN=0.
REQ-039 SAVE_DEPTH=4, push 100,001,010,001 -> Full=1, Depth=4; fifth Save -> Depth=4, Err=1; four Restores return 001,010,001,100 in order.
REQ-040 Empty stack, Restore -> CC unchanged, Err=1; with same-cycle Load_CC(Bus=0) -> CC=010.
REQ-041 Depth=2 with Save and Restore in the same cycle -> Depth=2, CC held, Err=1; then Reset_n pulse mid-cycle -> CC=010, Depth=0, Err=0 immediately, before the next edge.
REQ-042 Save with Load_CC(Bus=-1) when CC=001 -> stack top=001, CC=100; the following Restore -> CC=001.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared condition-code types, constants and the NZP classifier.
package cc_pkg;

  typedef logic [2:0] cc_t;

  localparam cc_t CC_N     = 3'b100;
  localparam cc_t CC_Z     = 3'b010;
  localparam cc_t CC_P     = 3'b001;
  localparam cc_t CC_RESET = CC_Z;

  // Widest bus the classifier accepts; narrower buses are zero-extended.
  localparam int unsigned CC_MAX_WIDTH = 64;

  // Classify a WIDTH-bit two's-complement value. Bits at and above width must
  // be zero so that the zero test only sees the live part of the bus.
  function automatic cc_t classify(input logic [CC_MAX_WIDTH-1:0] value,
                                   input int unsigned width);
    logic [5:0] sign_idx;
    cc_t        result;
    sign_idx = 6'(width - 1);
    if (value[sign_idx])
      result = CC_N;
    else if (value == '0)
      result = CC_Z;
    else
      result = CC_P;
    return result;
  endfunction

endpackage

// File: rtl/cc_save_stack.sv
// LIFO of condition codes saved across nested interrupt entries.
module cc_save_stack
  import cc_pkg::*;
#(
  parameter int SAVE_DEPTH = 4,
  localparam int DW = $clog2(SAVE_DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          push,
  input  logic          pop,
  input  cc_t           push_data,
  output cc_t           top_data,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  localparam int AW = (SAVE_DEPTH > 1) ? $clog2(SAVE_DEPTH) : 1;

  cc_t           slots [SAVE_DEPTH];
  logic [DW-1:0] depth_reg;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  // Next free slot is at depth, top of stack sits one below it.
  assign wr_idx   = depth_reg[AW-1:0];
  assign rd_idx   = AW'(depth_reg - 1'b1);
  assign top_data = slots[rd_idx];
  assign depth    = depth_reg;
  assign full     = (depth_reg == DW'(SAVE_DEPTH));
  assign empty    = (depth_reg == '0);

  // Slot storage; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge Clk) begin
    if (push && !full)
      slots[wr_idx] <= push_data;
  end

  // Occupancy counter, saturating at both ends.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      depth_reg <= '0;
    else if (push && !full)
      depth_reg <= depth_reg + 1'b1;
    else if (pop && !empty)
      depth_reg <= depth_reg - 1'b1;
  end

endmodule

// File: rtl/cc_ben_unit.sv
// Condition-code register, branch-enable evaluation and CC save/restore.
module cc_ben_unit
  import cc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SAVE_DEPTH = 4,
  localparam int DW = $clog2(SAVE_DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Bus,
  input  logic             Load_CC,
  input  logic [2:0]       IR_NZP,
  input  logic             Load_BEN,
  input  logic             Save,
  input  logic             Restore,
  output logic [2:0]       CC,
  output logic             BEN,
  output logic [DW-1:0]    Depth,
  output logic             Full,
  output logic             Empty,
  output logic             Err
);

  cc_t                    cc_reg;
  cc_t                    cc_next;
  cc_t                    top_cc;
  logic                   ben_reg;
  logic                   err_reg;
  logic                   do_push;
  logic                   do_pop;
  logic                   err_set;
  logic                   conflict;
  logic [CC_MAX_WIDTH-1:0] bus_ext;

  assign bus_ext  = CC_MAX_WIDTH'(Bus);
  assign conflict = Save && Restore;
  assign do_push  = Save && !Restore && !Full;
  assign do_pop   = Restore && !Save && !Empty;
  assign err_set  = conflict || (Save && !Restore && Full) || (Restore && !Save && Empty);

  cc_save_stack #(
    .SAVE_DEPTH(SAVE_DEPTH)
  ) u_stack (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .push     (do_push),
    .pop      (do_pop),
    .push_data(cc_reg),
    .top_data (top_cc),
    .depth    (Depth),
    .full     (Full),
    .empty    (Empty)
  );

  // CC source priority: a successful restore, then a conflicting save/restore
  // (which freezes CC), then a bus load.
  always_comb begin
    cc_next = cc_reg;
    if (do_pop)
      cc_next = top_cc;
    else if (conflict)
      cc_next = cc_reg;
    else if (Load_CC)
      cc_next = classify(bus_ext, WIDTH);
  end

  // Condition-code register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      cc_reg <= CC_RESET;
    else
      cc_reg <= cc_next;
  end

  // Branch enable samples the CC currently held, never the one being loaded.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      ben_reg <= 1'b0;
    else if (Load_BEN)
      ben_reg <= |(IR_NZP & cc_reg);
  end

  // Sticky error: overflow, underflow or a simultaneous save and restore.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      err_reg <= 1'b0;
    else if (err_set)
      err_reg <= 1'b1;
  end

  assign CC  = cc_reg;
  assign BEN = ben_reg;
  assign Err = err_reg;

endmodule

// File: tb/tb_cc_ben_unit.sv
// Directed bench for cc_ben_unit with a queue-based reference model.
module tb_cc_ben_unit;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [15:0] Bus;
  logic        Load_CC;
  logic [2:0]  IR_NZP;
  logic        Load_BEN;
  logic        Save;
  logic        Restore;
  logic [2:0]  CC;
  logic        BEN;
  logic [2:0]  Depth;
  logic        Full;
  logic        Empty;
  logic        Err;

  logic [7:0]  bus8;
  logic        load8;
  logic [2:0]  cc8;
  logic        ben8;
  logic [2:0]  depth8;
  logic        full8;
  logic        empty8;
  logic        err8;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0] m_cc;
  logic       m_ben;
  logic       m_err;
  logic [2:0] m_stack[$];
  bit         m_live = 1'b0;

  always #5 Clk = ~Clk;

  cc_ben_unit #(.WIDTH(16), .SAVE_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Bus(Bus), .Load_CC(Load_CC), .IR_NZP(IR_NZP),
    .Load_BEN(Load_BEN), .Save(Save), .Restore(Restore), .CC(CC), .BEN(BEN),
    .Depth(Depth), .Full(Full), .Empty(Empty), .Err(Err)
  );

  cc_ben_unit #(.WIDTH(8), .SAVE_DEPTH(DEPTH)) dut8 (
    .Clk(Clk), .Reset_n(Reset_n), .Bus(bus8), .Load_CC(load8), .IR_NZP(3'b000),
    .Load_BEN(1'b0), .Save(1'b0), .Restore(1'b0), .CC(cc8), .BEN(ben8),
    .Depth(depth8), .Full(full8), .Empty(empty8), .Err(err8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [2:0] model_class(input logic [15:0] b);
    if ($signed(b) < 0)  return 3'b100;
    else if (b == 16'd0) return 3'b010;
    else                 return 3'b001;
  endfunction

  task automatic model_reset();
    m_cc  = 3'b010;
    m_ben = 1'b0;
    m_err = 1'b0;
    m_stack.delete();
  endtask

  // Apply one cycle of stimulus, then advance the model by the same rules.
  task automatic cycle(input logic [15:0] b, input logic lcc, input logic [2:0] nzp,
                       input logic lben, input logic sv, input logic rs);
    Bus = b; Load_CC = lcc; IR_NZP = nzp; Load_BEN = lben; Save = sv; Restore = rs;
    @(posedge Clk);
    #1;
    if (lben) m_ben = |(nzp & m_cc);
    if (sv && rs) begin
      m_err = 1'b1;
    end else if (sv) begin
      if (m_stack.size() == DEPTH) m_err = 1'b1;
      else m_stack.push_back(m_cc);
      if (lcc) m_cc = model_class(b);
    end else if (rs) begin
      if (m_stack.size() == 0) begin
        m_err = 1'b1;
        if (lcc) m_cc = model_class(b);
      end else begin
        m_cc = m_stack.pop_back();
      end
    end else if (lcc) begin
      m_cc = model_class(b);
    end
    $display("cycle bus=%h lcc=%0b nzp=%b lben=%0b save=%0b restore=%0b -> model cc=%b ben=%0b depth=%0d err=%0b",
             b, lcc, nzp, lben, sv, rs, m_cc, m_ben, m_stack.size(), m_err);
  endtask

  // Assert reset partway between edges and confirm it acts without a clock.
  task automatic reset_mid(input string tag);
    #2;
    Reset_n = 1'b0;
    #1;
    check({tag, "_cc"},    32'(CC),    32'h2);
    check({tag, "_depth"}, 32'(Depth), 32'h0);
    check({tag, "_err"},   32'(Err),   32'h0);
    check({tag, "_ben"},   32'(BEN),   32'h0);
    model_reset();
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  // Compare every output against the model once per cycle, mid-period.
  always @(negedge Clk) begin
    if (m_live && Reset_n === 1'b1) begin
      check("cc",    32'(CC),    32'(m_cc));
      check("ben",   32'(BEN),   32'(m_ben));
      check("depth", 32'(Depth), 32'(m_stack.size()));
      check("full",  32'(Full),  32'(m_stack.size() == DEPTH));
      check("empty", 32'(Empty), 32'(m_stack.size() == 0));
      check("err",   32'(Err),   32'(m_err));
    end
  end

  initial begin
    Reset_n = 1'b0;
    Bus = '0; Load_CC = 0; IR_NZP = '0; Load_BEN = 0; Save = 0; Restore = 0;
    bus8 = '0; load8 = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    m_live  = 1'b1;
    check("rst_cc",    32'(CC),    32'h2);
    check("rst_ben",   32'(BEN),   32'h0);
    check("rst_depth", 32'(Depth), 32'h0);
    check("rst_empty", 32'(Empty), 32'h1);
    check("rst_err",   32'(Err),   32'h0);

    // Narrow-bus instance: sign bit is bit 7.
    bus8 = 8'h80; load8 = 1'b1;
    cycle(16'h0, 0, 3'b000, 0, 0, 0);
    check("w8_neg", 32'(cc8), 32'h4);
    bus8 = 8'h7F;
    cycle(16'h0, 0, 3'b000, 0, 0, 0);
    check("w8_pos", 32'(cc8), 32'h1);
    load8 = 1'b0;

    // Classification.
    cycle(16'h8000, 1, 3'b000, 0, 0, 0); check("cls_neg",  32'(CC), 32'h4);
    cycle(16'h0000, 1, 3'b000, 0, 0, 0); check("cls_zero", 32'(CC), 32'h2);
    cycle(16'h0001, 1, 3'b000, 0, 0, 0); check("cls_pos",  32'(CC), 32'h1);
    cycle(16'h7FFF, 1, 3'b000, 0, 0, 0); check("cls_max",  32'(CC), 32'h1);

    // Branch enable.
    cycle(16'h0000, 1, 3'b000, 0, 0, 0);
    cycle(16'h0000, 0, 3'b010, 1, 0, 0); check("ben_z",    32'(BEN), 32'h1);
    cycle(16'h0000, 0, 3'b101, 1, 0, 0); check("ben_np",   32'(BEN), 32'h0);
    cycle(16'h0000, 0, 3'b010, 1, 0, 0);
    cycle(16'h0000, 0, 3'b000, 1, 0, 0); check("ben_none", 32'(BEN), 32'h0);
    cycle(16'h0001, 1, 3'b001, 1, 0, 0); check("ben_old",  32'(BEN), 32'h0);
    check("ben_old_cc", 32'(CC), 32'h1);
    cycle(16'h0000, 0, 3'b001, 1, 0, 0); check("ben_p",    32'(BEN), 32'h1);
    cycle(16'h0000, 0, 3'b000, 0, 0, 0); check("ben_hold", 32'(BEN), 32'h1);

    // Fill the stack with 100,001,010,001.
    cycle(16'h8000, 1, 3'b000, 0, 0, 0); cycle(16'h0, 0, 3'b000, 0, 1, 0);
    cycle(16'h0001, 1, 3'b000, 0, 0, 0); cycle(16'h0, 0, 3'b000, 0, 1, 0);
    cycle(16'h0000, 1, 3'b000, 0, 0, 0); cycle(16'h0, 0, 3'b000, 0, 1, 0);
    cycle(16'h0001, 1, 3'b000, 0, 0, 0); cycle(16'h0, 0, 3'b000, 0, 1, 0);
    check("fill_full",  32'(Full),  32'h1);
    check("fill_depth", 32'(Depth), 32'h4);
    check("fill_err",   32'(Err),   32'h0);
    cycle(16'h8000, 1, 3'b000, 0, 1, 0);
    check("ovf_depth", 32'(Depth), 32'h4);
    check("ovf_err",   32'(Err),   32'h1);
    check("ovf_cc",    32'(CC),    32'h4);
    cycle(16'h0, 0, 3'b000, 0, 0, 1);    check("pop1", 32'(CC), 32'h1);
    cycle(16'h8000, 1, 3'b000, 0, 0, 1); check("pop2", 32'(CC), 32'h2);
    cycle(16'h0, 0, 3'b000, 0, 0, 1);    check("pop3", 32'(CC), 32'h1);
    cycle(16'h0, 0, 3'b000, 0, 0, 1);    check("pop4", 32'(CC), 32'h4);
    check("pop_empty", 32'(Empty), 32'h1);

    // Underflow.
    cycle(16'h0, 0, 3'b000, 0, 0, 1); check("unf_cc", 32'(CC), 32'h4);
    check("unf_depth", 32'(Depth), 32'h0);
    cycle(16'h0, 1, 3'b000, 0, 0, 1); check("unf_load", 32'(CC), 32'h2);

    reset_mid("rst1");

    // Save and restore together at depth 2.
    cycle(16'h0, 0, 3'b000, 0, 1, 0);
    cycle(16'h0001, 1, 3'b000, 0, 0, 0);
    cycle(16'h0, 0, 3'b000, 0, 1, 0);
    check("sr_pre_err", 32'(Err), 32'h0);
    cycle(16'h8000, 1, 3'b000, 0, 1, 1);
    check("sr_depth", 32'(Depth), 32'h2);
    check("sr_cc",    32'(CC),    32'h1);
    check("sr_err",   32'(Err),   32'h1);
    reset_mid("rst2");

    // Saved contexts are gone after reset.
    cycle(16'h0, 0, 3'b000, 0, 0, 1);
    check("post_rst_err", 32'(Err), 32'h1);
    check("post_rst_cc",  32'(CC),  32'h2);

    // Save together with a load; restore then evaluates BEN on pre-restore CC.
    cycle(16'h0001, 1, 3'b000, 0, 0, 0);
    cycle(16'hFFFF, 1, 3'b000, 0, 1, 0);
    check("sl_cc",    32'(CC),    32'h4);
    check("sl_depth", 32'(Depth), 32'h1);
    cycle(16'h0, 0, 3'b100, 1, 0, 1);
    check("sl_pop_cc",  32'(CC),  32'h1);
    check("sl_pop_ben", 32'(BEN), 32'h1);

    cycle(16'h0, 0, 3'b000, 0, 0, 0);
    @(negedge Clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
